// File: rtl/seq_pkg.sv
// Shared types and constants for the LEGv8 single-clock phase sequencer.
// Phase encoding, strobe bit positions and the phase-to-strobe decode live here.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        IF   = 3'd1,
        ID   = 3'd2,
        EX   = 3'd3,
        WB   = 3'd4,
        MW   = 3'd5,
        HALT = 3'd6
    } phase_t;

    localparam int STB_IMEM     = 0;
    localparam int STB_RF_READ  = 1;
    localparam int STB_EXMEM    = 2;
    localparam int STB_RF_WRITE = 3;
    localparam int STB_PC       = 4;
    localparam int STB_W        = 5;

    localparam int DEF_CNT_W        = 64;
    localparam int DEF_MULT_TIMEOUT = 128;
    localparam int DEF_MAX_INSTR    = 0;

    // Writeback and PC advance share the WB phase.
    function automatic logic [STB_W-1:0] strobes_for(input phase_t p);
        logic [STB_W-1:0] s;
        s = '0;
        case (p)
            IF: s[STB_IMEM]    = 1'b1;
            ID: s[STB_RF_READ] = 1'b1;
            EX: s[STB_EXMEM]   = 1'b1;
            WB: begin
                s[STB_RF_WRITE] = 1'b1;
                s[STB_PC]       = 1'b1;
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Multiplier wait counter: counts cycles spent in MW and flags the cycle on
// which the wait budget runs out without a multiplier result.
module seq_watchdog
    import seq_pkg::*;
#(
    parameter int MULT_TIMEOUT = DEF_MULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic done,
    output logic expired
);

    localparam int WD_W = $clog2(MULT_TIMEOUT + 1);
    localparam logic [WD_W-1:0] LAST = WD_W'(MULT_TIMEOUT - 1);

    logic [WD_W-1:0] wait_cnt;

    // wait_cnt holds the number of MW cycles already completed, so the
    // current MW cycle is number wait_cnt+1.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wait_cnt <= '0;
        end else if (en && (wait_cnt != LAST)) begin
            wait_cnt <= wait_cnt + WD_W'(1);
        end
    end

    assign expired = en && !done && (wait_cnt == LAST);

endmodule

// File: rtl/cycle_sequencer.sv
// Single-clock phase sequencer for the nonpipelined LEGv8 core: per-stage
// enable strobes, multiplier stall watchdog, halt control and perf counters.
//
//   state | meaning
//   IDLE  | waiting for run (halt_req goes straight to HALT)
//   IF    | instruction fetch, imem_en high
//   ID    | register read / decode, rf_read_en high
//   EX    | ALU / SREG / data memory, exmem_en high
//   WB    | writeback and PC load, rf_write_en and pc_en high
//   MW    | multiplier wait, all strobes low, watchdog running
//   HALT  | stopped until reset
module cycle_sequencer
    import seq_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int MULT_TIMEOUT = DEF_MULT_TIMEOUT,
    parameter int MAX_INSTR    = DEF_MAX_INSTR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             halt_req,
    input  logic             stall,
    input  logic             multiplier_done,
    output logic             imem_en,
    output logic             rf_read_en,
    output logic             exmem_en,
    output logic             rf_write_en,
    output logic             pc_en,
    output logic [2:0]       phase,
    output logic             halted,
    output logic             timeout_err,
    output logic [CNT_W-1:0] retired_count,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [CNT_W-1:0] BUDGET = CNT_W'(MAX_INSTR);

    phase_t           state;
    phase_t           state_next;
    logic             pending;
    logic             pending_next;
    logic             timeout_hit;
    logic             wd_expired;
    logic             budget_done;
    logic             busy;
    logic [STB_W-1:0] strobes_q;

    seq_watchdog #(
        .MULT_TIMEOUT(MULT_TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (state == EX),
        .en     (state == MW),
        .done   (multiplier_done),
        .expired(wd_expired)
    );

    assign budget_done = (MAX_INSTR != 0) && ((retired_count + CNT_W'(1)) == BUDGET);
    assign busy        = (state != IDLE) && (state != HALT);

    always_comb begin
        state_next  = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (halt_req) begin
                    state_next = HALT;
                end else if (run) begin
                    state_next = IF;
                end
            end
            IF: state_next = ID;
            ID: state_next = EX;
            EX: state_next = stall ? MW : WB;
            MW: begin
                if (multiplier_done) begin
                    state_next = WB;
                end else if (wd_expired) begin
                    state_next  = HALT;
                    timeout_hit = 1'b1;
                end
            end
            WB: begin
                // A halt request arriving in the WB cycle itself still stops here.
                if (pending || halt_req || budget_done) begin
                    state_next = HALT;
                end else if (!run) begin
                    state_next = IDLE;
                end else begin
                    state_next = IF;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pending_next = pending;
        if (state_next == HALT) begin
            pending_next = 1'b0;
        end else if (busy && halt_req) begin
            pending_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pending       <= 1'b0;
            strobes_q     <= '0;
            halted        <= 1'b0;
            timeout_err   <= 1'b0;
            retired_count <= '0;
            cycle_count   <= '0;
        end else begin
            state     <= state_next;
            pending   <= pending_next;
            strobes_q <= strobes_for(state_next);
            halted    <= (state_next == HALT);
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
            if (state == WB) begin
                retired_count <= retired_count + CNT_W'(1);
            end
            if (busy && (cycle_count != '1)) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
        end
    end

    assign phase       = state;
    assign imem_en     = strobes_q[STB_IMEM];
    assign rf_read_en  = strobes_q[STB_RF_READ];
    assign exmem_en    = strobes_q[STB_EXMEM];
    assign rf_write_en = strobes_q[STB_RF_WRITE];
    assign pc_en       = strobes_q[STB_PC];

endmodule

// File: tb/tb_cycle_sequencer.sv
// Bench for cycle_sequencer: directed scenarios plus a randomized run compared
// cycle by cycle against an instruction-level reference model.
module tb_cycle_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic run = 1'b0;
    logic halt_req = 1'b0;
    logic stall = 1'b0;
    logic multiplier_done = 1'b0;

    logic        a_imem, a_rfr, a_exm, a_rfw, a_pc, a_halted, a_terr;
    logic [2:0]  a_phase;
    logic [63:0] a_ret, a_cyc;
    logic        b_imem, b_rfr, b_exm, b_rfw, b_pc, b_halted, b_terr;
    logic [2:0]  b_phase;
    logic [63:0] b_ret, b_cyc;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    cycle_sequencer #(.CNT_W(64), .MULT_TIMEOUT(128), .MAX_INSTR(0)) dut_a (
        .clk(clk), .reset(reset), .run(run), .halt_req(halt_req), .stall(stall),
        .multiplier_done(multiplier_done), .imem_en(a_imem), .rf_read_en(a_rfr),
        .exmem_en(a_exm), .rf_write_en(a_rfw), .pc_en(a_pc), .phase(a_phase),
        .halted(a_halted), .timeout_err(a_terr), .retired_count(a_ret), .cycle_count(a_cyc)
    );

    cycle_sequencer #(.CNT_W(64), .MULT_TIMEOUT(8), .MAX_INSTR(5)) dut_b (
        .clk(clk), .reset(reset), .run(run), .halt_req(halt_req), .stall(stall),
        .multiplier_done(multiplier_done), .imem_en(b_imem), .rf_read_en(b_rfr),
        .exmem_en(b_exm), .rf_write_en(b_rfw), .pc_en(b_pc), .phase(b_phase),
        .halted(b_halted), .timeout_err(b_terr), .retired_count(b_ret), .cycle_count(b_cyc)
    );

    logic [9:0]  obs_v [2];
    logic [63:0] obs_ret [2];
    logic [63:0] obs_cyc [2];
    assign obs_v[0]   = {a_phase, a_imem, a_rfr, a_exm, a_rfw, a_pc, a_halted, a_terr};
    assign obs_v[1]   = {b_phase, b_imem, b_rfr, b_exm, b_rfw, b_pc, b_halted, b_terr};
    assign obs_ret[0] = a_ret;
    assign obs_ret[1] = b_ret;
    assign obs_cyc[0] = a_cyc;
    assign obs_cyc[1] = b_cyc;

    // Reference model: mode 0 stopped-idle, 1 executing, 2 halted.
    // pos is the step of the current instruction: 0 fetch, 1 decode,
    // 2 execute, 3 writeback, 4 waiting for the multiplier.
    int          m_mode [2];
    int          m_pos  [2];
    int          m_wait [2];
    longint      m_ret  [2];
    longint      m_cyc  [2];
    bit          m_pend [2];
    bit          m_terr [2];
    int          m_to   [2] = '{128, 8};
    int          m_max  [2] = '{0, 5};

    task automatic model_step();
        bit pend_now;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_mode[i] = 0; m_pos[i] = 0; m_wait[i] = 0;
                m_ret[i] = 0; m_cyc[i] = 0; m_pend[i] = 0; m_terr[i] = 0;
            end else if (m_mode[i] == 0) begin
                if (halt_req) m_mode[i] = 2;
                else if (run) begin m_mode[i] = 1; m_pos[i] = 0; end
            end else if (m_mode[i] == 1) begin
                pend_now = m_pend[i] | halt_req;
                m_cyc[i]++;
                case (m_pos[i])
                    0: m_pos[i] = 1;
                    1: m_pos[i] = 2;
                    2: begin
                        if (stall) begin m_pos[i] = 4; m_wait[i] = 0; end
                        else m_pos[i] = 3;
                    end
                    4: begin
                        m_wait[i]++;
                        if (multiplier_done) m_pos[i] = 3;
                        else if (m_wait[i] == m_to[i]) begin
                            m_mode[i] = 2; m_terr[i] = 1; pend_now = 0;
                        end
                    end
                    default: begin
                        m_ret[i]++;
                        if (pend_now || (m_max[i] != 0 && m_ret[i] == m_max[i])) begin
                            m_mode[i] = 2; pend_now = 0;
                        end else if (!run) m_mode[i] = 0;
                        else m_pos[i] = 0;
                    end
                endcase
                m_pend[i] = pend_now;
            end
        end
    endtask

    function automatic logic [9:0] exp_vec(input int i);
        logic [2:0] ph;
        logic [4:0] s;
        s = 5'b00000;
        if (m_mode[i] == 0) ph = 3'd0;
        else if (m_mode[i] == 2) ph = 3'd6;
        else begin
            case (m_pos[i])
                0: begin ph = 3'd1; s = 5'b10000; end
                1: begin ph = 3'd2; s = 5'b01000; end
                2: begin ph = 3'd3; s = 5'b00100; end
                3: begin ph = 3'd4; s = 5'b00011; end
                default: ph = 3'd5;
            endcase
        end
        return {ph, s, (m_mode[i] == 2), m_terr[i]};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; halt_req = 1'b0; stall = 1'b0; multiplier_done = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({a_phase, a_imem, a_rfr, a_exm, a_rfw, a_pc, a_halted, a_terr} !== 10'd0 || a_ret !== 64'd0 || a_cyc !== 64'd0) begin
            fails++; $display("FAIL reset_a got phase=%0d halted=%0b terr=%0b ret=%0d cyc=%0d exp all zero", a_phase, a_halted, a_terr, a_ret, a_cyc);
        end else passes++;
        checks++;
        if ({b_phase, b_imem, b_rfr, b_exm, b_rfw, b_pc, b_halted, b_terr} !== 10'd0 || b_ret !== 64'd0 || b_cyc !== 64'd0) begin
            fails++; $display("FAIL reset_b got phase=%0d halted=%0b terr=%0b ret=%0d cyc=%0d exp all zero", b_phase, b_halted, b_terr, b_ret, b_cyc);
        end else passes++;
    endtask

    task automatic test_basic();
        do_reset();
        run = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if (a_phase !== 3'((k - 1) % 4 + 1) || a_pc !== (k % 4 == 0) || a_rfw !== (k % 4 == 0)) begin
                fails++; $display("FAIL basic_seq cycle=%0d got phase=%0d pc_en=%0b exp phase=%0d pc_en=%0b", k, a_phase, a_pc, (k - 1) % 4 + 1, (k % 4 == 0));
            end else passes++;
            if (k == 12) run = 1'b0;
        end
        tick();
        checks++;
        if (a_phase !== 3'd0 || a_ret !== 64'd3 || a_cyc !== 64'd12) begin
            fails++; $display("FAIL basic_end got phase=%0d ret=%0d cyc=%0d exp 0/3/12", a_phase, a_ret, a_cyc);
        end else passes++;
    endtask

    task automatic test_multiply();
        do_reset();
        run = 1'b1; stall = 1'b1;
        repeat (3) tick();
        for (int m = 1; m <= 10; m++) begin
            tick();
            if (m == 1) stall = 1'b0;
            checks++;
            if (a_phase !== 3'd5 || {a_imem, a_rfr, a_exm, a_rfw, a_pc} !== 5'b0) begin
                fails++; $display("FAIL mul_wait mw=%0d got phase=%0d strobes=%b exp 5/00000", m, a_phase, {a_imem, a_rfr, a_exm, a_rfw, a_pc});
            end else passes++;
            if (m == 10) multiplier_done = 1'b1;
        end
        tick();
        multiplier_done = 1'b0; run = 1'b0;
        checks++;
        if (a_phase !== 3'd4 || a_rfw !== 1'b1 || a_pc !== 1'b1) begin
            fails++; $display("FAIL mul_wb got phase=%0d rfw=%0b pc=%0b exp 4/1/1", a_phase, a_rfw, a_pc);
        end else passes++;
        tick();
        checks++;
        if (a_phase !== 3'd0 || a_ret !== 64'd1 || a_cyc !== 64'd14) begin
            fails++; $display("FAIL mul_end got phase=%0d ret=%0d cyc=%0d exp 0/1/14", a_phase, a_ret, a_cyc);
        end else passes++;
    endtask

    task automatic test_timeout();
        do_reset();
        run = 1'b1; stall = 1'b1;
        repeat (3) tick();
        for (int m = 1; m <= 8; m++) begin
            tick();
            if (m == 1) stall = 1'b0;
            checks++;
            if (b_phase !== 3'd5 || b_halted !== 1'b0 || b_terr !== 1'b0 || b_rfw !== 1'b0) begin
                fails++; $display("FAIL tmo_wait mw=%0d got phase=%0d halted=%0b terr=%0b exp 5/0/0", m, b_phase, b_halted, b_terr);
            end else passes++;
        end
        tick();
        checks++;
        if (b_phase !== 3'd6 || b_halted !== 1'b1 || b_terr !== 1'b1 || b_rfw !== 1'b0 || b_pc !== 1'b0 || b_ret !== 64'd0) begin
            fails++; $display("FAIL tmo_fire got phase=%0d halted=%0b terr=%0b rfw=%0b pc=%0b ret=%0d exp 6/1/1/0/0/0", b_phase, b_halted, b_terr, b_rfw, b_pc, b_ret);
        end else passes++;
        checks++;
        if (a_phase !== 3'd5 || a_terr !== 1'b0) begin
            fails++; $display("FAIL tmo_long_wd got phase=%0d terr=%0b exp 5/0", a_phase, a_terr);
        end else passes++;
        repeat (3) tick();
        checks++;
        if (b_halted !== 1'b1 || b_terr !== 1'b1 || b_ret !== 64'd0) begin
            fails++; $display("FAIL tmo_sticky got halted=%0b terr=%0b ret=%0d exp 1/1/0", b_halted, b_terr, b_ret);
        end else passes++;
    endtask

    task automatic test_max_instr();
        do_reset();
        run = 1'b1;
        repeat (20) tick();
        checks++;
        if (b_phase !== 3'd4 || b_halted !== 1'b0) begin
            fails++; $display("FAIL budget_last_wb got phase=%0d halted=%0b exp 4/0", b_phase, b_halted);
        end else passes++;
        tick();
        checks++;
        if (b_phase !== 3'd6 || b_halted !== 1'b1 || b_ret !== 64'd5 || b_cyc !== 64'd20) begin
            fails++; $display("FAIL budget_halt got phase=%0d halted=%0b ret=%0d cyc=%0d exp 6/1/5/20", b_phase, b_halted, b_ret, b_cyc);
        end else passes++;
        repeat (4) tick();
        checks++;
        if (b_ret !== 64'd5 || b_cyc !== 64'd20 || b_imem !== 1'b0) begin
            fails++; $display("FAIL budget_frozen got ret=%0d cyc=%0d imem=%0b exp 5/20/0", b_ret, b_cyc, b_imem);
        end else passes++;
    endtask

    task automatic test_halt_req();
        do_reset();
        run = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 6) halt_req = 1'b1;
            if (k == 7) halt_req = 1'b0;
        end
        checks++;
        if (a_phase !== 3'd4 || a_rfw !== 1'b1) begin
            fails++; $display("FAIL halt_wb got phase=%0d rfw=%0b exp 4/1", a_phase, a_rfw);
        end else passes++;
        tick();
        checks++;
        if (a_phase !== 3'd6 || a_halted !== 1'b1 || a_ret !== 64'd2) begin
            fails++; $display("FAIL halt_req got phase=%0d halted=%0b ret=%0d exp 6/1/2", a_phase, a_halted, a_ret);
        end else passes++;
    endtask

    task automatic test_run_drop();
        do_reset();
        run = 1'b1;
        repeat (3) tick();
        run = 1'b0;
        tick();
        checks++;
        if (a_phase !== 3'd4 || a_rfw !== 1'b1 || a_pc !== 1'b1) begin
            fails++; $display("FAIL drop_wb got phase=%0d rfw=%0b pc=%0b exp 4/1/1", a_phase, a_rfw, a_pc);
        end else passes++;
        tick();
        checks++;
        if (a_phase !== 3'd0 || a_ret !== 64'd1 || a_halted !== 1'b0) begin
            fails++; $display("FAIL drop_idle got phase=%0d ret=%0d halted=%0b exp 0/1/0", a_phase, a_ret, a_halted);
        end else passes++;
    endtask

    task automatic test_reset_in_mw();
        do_reset();
        run = 1'b1; stall = 1'b1;
        repeat (4) tick();
        stall = 1'b0;
        repeat (2) tick();
        checks++;
        if (a_phase !== 3'd5) begin
            fails++; $display("FAIL rst_mw_pre got phase=%0d exp 5", a_phase);
        end else passes++;
        reset = 1'b1;
        tick();
        reset = 1'b0; run = 1'b0; multiplier_done = 1'b1;
        checks++;
        if ({a_phase, a_imem, a_rfr, a_exm, a_rfw, a_pc, a_halted, a_terr} !== 10'd0 || a_ret !== 64'd0 || a_cyc !== 64'd0) begin
            fails++; $display("FAIL rst_mw got phase=%0d rfw=%0b ret=%0d cyc=%0d exp all zero", a_phase, a_rfw, a_ret, a_cyc);
        end else passes++;
        tick();
        multiplier_done = 1'b0;
        checks++;
        if (a_phase !== 3'd0 || a_rfw !== 1'b0 || a_ret !== 64'd0) begin
            fails++; $display("FAIL rst_late_done got phase=%0d rfw=%0b ret=%0d exp 0/0/0", a_phase, a_rfw, a_ret);
        end else passes++;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            reset           = ($urandom_range(0, 79) == 0);
            run             = ($urandom_range(0, 9) != 0);
            halt_req        = ($urandom_range(0, 49) == 0);
            stall           = ($urandom_range(0, 3) == 0);
            multiplier_done = ($urandom_range(0, 5) == 0);
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_v[i] !== exp_vec(i) || obs_ret[i] !== 64'(m_ret[i]) || obs_cyc[i] !== 64'(m_cyc[i])) begin
                    fails++;
                    $display("FAIL random dut=%0d step=%0d got vec=%b ret=%0d cyc=%0d exp vec=%b ret=%0d cyc=%0d",
                             i, n, obs_v[i], obs_ret[i], obs_cyc[i], exp_vec(i), m_ret[i], m_cyc[i]);
                end else passes++;
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multiply();
        test_timeout();
        test_max_instr();
        test_halt_req();
        test_run_drop();
        test_reset_in_mw();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
